muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal values are even numbers of 8 or more).
REQ-002 clk  input  1  rising-edge clock shared with the pipeline.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  issue strobe from the execute stage; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
REQ-006 a  input  WIDTH  rs operand, which is the dividend for div/divu.
REQ-007 b  input  WIDTH  rt operand, which is the divisor for div/divu.
REQ-008 rd_hilo  input  1  high while an mfhi/mflo is in decode.
REQ-009 busy  output  1  high while the state is CALC or FIX.
REQ-010 done  output  1  registered one-cycle completion pulse.
REQ-011 div_by_zero  output  1  registered; valid only while done is high.
REQ-012 hi  output  WIDTH  HI register.
REQ-013 lo  output  WIDTH  LO register.
REQ-014 stall_d  output  1  combinational pipeline stall request.

Function
REQ-015 The FSM SHALL have the states IDLE, CALC and FIX; no other states are reachable.
REQ-016 In IDLE with start=1, the edge SHALL capture op, a and b into internal registers and SHALL clear the step counter to 0; a/b changes after that edge SHALL have no effect on the result.
REQ-017 At that same edge the state SHALL go to CALC, except for div/divu with b=0, which SHALL go directly to FIX.
REQ-018 Signed ops SHALL operate on operand magnitudes; the magnitude of the most-negative value SHALL be 2^(WIDTH-1), handled unsigned without overflow.
REQ-019 mult/multu SHALL perform one radix-2 shift-add step per CALC cycle over a 2*WIDTH-bit accumulator.
REQ-020 div/divu SHALL perform one restoring shift-subtract step per CALC cycle and SHALL produce a WIDTH-bit quotient and a WIDTH-bit remainder.
REQ-021 The counter SHALL increment once per CALC edge; the edge on which the counter reaches WIDTH SHALL move the state to FIX.
REQ-022 The FIX edge SHALL apply the sign fix-up, write hi/lo, set done=1 and return the state to IDLE.
REQ-023 Sign fix-up: a signed mult product SHALL be negated when the operand signs differ.
REQ-024 Sign fix-up: a signed div quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the dividend's sign.
REQ-025 mult/multu SHALL write hi = product[2*WIDTH-1:WIDTH] and lo = product[WIDTH-1:0].
REQ-026 div/divu SHALL write lo = quotient and hi = remainder.
REQ-027 Divide by zero SHALL write hi = captured a, lo = all ones, and div_by_zero=1; in every other case div_by_zero SHALL be 0.
REQ-028 Signed div of the most-negative value by -1 SHALL yield lo = 2^(WIDTH-1) bit pattern and hi = 0, with no flag.
REQ-029 Latency for normal ops: if start is sampled at edge E0, done SHALL be high for exactly the cycle following edge E0+WIDTH+1, with hi/lo valid in that cycle.
REQ-030 Latency for divide by zero: done SHALL be high for the cycle following edge E0+1.
REQ-031 done SHALL be cleared on every edge other than a FIX edge.
REQ-032 hi/lo SHALL change only on a FIX edge and SHALL otherwise hold their values.
REQ-033 start while busy SHALL be ignored, with no change to the captured operands or the in-flight operation.
REQ-034 start in the done cycle SHALL be accepted, because the state is IDLE in that cycle.
REQ-035 stall_d SHALL equal busy & (start | rd_hilo).
REQ-036 There SHALL be no abort input; only rst_n SHALL cancel an operation.

Reset
REQ-037 rst_n low SHALL immediately force state=IDLE, counter=0, busy=0, done=0, div_by_zero=0, hi=0 and lo=0, independent of clk.
REQ-038 Reset mid-operation SHALL discard the partial result; hi/lo SHALL read 0 afterwards, not any prior value.
REQ-039 The first start sampled after rst_n deasserts SHALL be processed normally.

Verification (WIDTH=32)
REQ-040 mult: a=0xFFFFFFFE, b=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; done in the cycle after edge E0+33; busy high for exactly 33 cycles.
REQ-041 multu: a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; mult: a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
REQ-042 div: a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-043 divu: a=10, b=0 -> div_by_zero=1, hi=0x0000000A, lo=0xFFFFFFFF; done in the cycle after edge E0+1; the next op clears the flag.
REQ-044 Second start plus rd_hilo at step 5 of a multu -> stall_d=1 while busy; the second start is dropped; results are from the first op only; a start in the done cycle is accepted.
REQ-045 rst_n pulsed low at step 10 of a div -> busy=0, hi=lo=0 asynchronously, no done pulse; a following multu 6*7 -> lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide, one step per cycle, with sign fix-up in FIX.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hilo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall_d
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic [1:0]           opReg;
  logic [WIDTH-1:0]     aReg;
  logic [WIDTH-1:0]     operand;
  logic [2*WIDTH-1:0]   prod;
  logic                 negA;
  logic                 negB;
  logic                 divZero;

  logic                 inSigned;
  logic                 inNegA;
  logic                 inNegB;
  logic [WIDTH-1:0]     inMagA;
  logic [WIDTH-1:0]     inMagB;
  logic                 inDivZero;

  logic [WIDTH:0]       mulSum;
  logic [WIDTH:0]       divShift;
  logic [WIDTH:0]       divDiff;
  logic [2*WIDTH-1:0]   mulNext;
  logic [2*WIDTH-1:0]   divNext;
  logic [WIDTH-1:0]     resHi;
  logic [WIDTH-1:0]     resLo;

  // Magnitudes of the incoming operands; the most-negative value maps to 2^(WIDTH-1) unsigned.
  assign inSigned  = ~op[0];
  assign inNegA    = inSigned & a[WIDTH-1];
  assign inNegB    = inSigned & b[WIDTH-1];
  assign inMagA    = inNegA ? -a : a;
  assign inMagB    = inNegB ? -b : b;
  assign inDivZero = op[1] && (b == '0);

  // Multiply: prod = {partial sum, multiplier}; divide: prod = {remainder, dividend/quotient}.
  assign mulSum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? operand : {WIDTH{1'b0}})};
  assign mulNext  = {mulSum, prod[WIDTH-1:1]};
  assign divShift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, operand};
  assign divNext  = divDiff[WIDTH] ? {divShift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                                   : {divDiff[WIDTH-1:0],  prod[WIDTH-2:0], 1'b1};

  always_comb begin
    // NOTE: defaults first so every path assigns resHi/resLo and no latch is inferred.
    resHi = prod[2*WIDTH-1:WIDTH];
    resLo = prod[WIDTH-1:0];
    if (divZero) begin
      resHi = aReg;
      resLo = '1;
    end else if (opReg[1]) begin
      if (negA ^ negB) resLo = -prod[WIDTH-1:0];
      if (negA)        resHi = -prod[2*WIDTH-1:WIDTH];
    end else if (negA ^ negB) begin
      {resHi, resLo} = -prod;
    end
  end

  assign busy    = (state == CALC) || (state == FIX);
  assign stall_d = busy & (start | rd_hilo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      opReg       <= '0;
      aReg        <= '0;
      operand     <= '0;
      prod        <= '0;
      negA        <= 1'b0;
      negB        <= 1'b0;
      divZero     <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      // NOTE: non-blocking (<=) for every register so each update sees pre-edge values.
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            opReg   <= op;
            aReg    <= a;
            negA    <= inNegA;
            negB    <= inNegB;
            divZero <= inDivZero;
            count   <= '0;
            if (op[1]) begin
              operand <= inMagB;
              prod    <= {{WIDTH{1'b0}}, inMagA};
            end else begin
              operand <= inMagA;
              prod    <= {{WIDTH{1'b0}}, inMagB};
            end
            state <= inDivZero ? FIX : CALC;
          end
        end
        CALC: begin
          count <= count + 1'b1;
          prod  <= opReg[1] ? divNext : mulNext;
          if (count == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          hi          <= resHi;
          lo          <= resLo;
          done        <= 1'b1;
          div_by_zero <= divZero;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
